// File: rtl/matmul_sequencer_pkg.sv
// Shared configuration for the matmul job sequencer: array geometry, buffer shapes,
// the drain watchdog limit and the sequencer state encoding.
package Config;

    localparam int sys_rows      = 3;
    localparam int sys_cols      = 3;
    localparam int W_BITWIDTH    = 8;
    localparam int A_rows        = 4;
    localparam int A_cols        = 3;
    localparam int INSTR_SIZE    = 2;
    localparam int DRAIN_TIMEOUT = 256;

    localparam int W_ADDR_W = $clog2(sys_rows);
    localparam int A_ADDR_W = $clog2(A_rows);
    localparam int CNT_W    = $clog2(A_rows + 1);
    localparam int WD_W     = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        GAP_W,
        LOAD_A,
        GAP_A,
        ISSUE,
        START,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/matmul_sequencer_drain_tracker.sv
// Per-column result counters for the drain phase; reports completion one cycle
// early (including this cycle's strobes) and flags strobes on already-full columns.
module col_drain_tracker
    import Config::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [sys_cols-1:0] read_out,
    output logic                all_done_next,
    output logic                overflow
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(A_rows);

    logic [CNT_W-1:0]    cnt [sys_cols];
    logic [sys_cols-1:0] col_full;
    logic [sys_cols-1:0] col_full_next;
    logic [sys_cols-1:0] col_ovf;

    always_comb begin
        col_full      = '0;
        col_full_next = '0;
        col_ovf       = '0;
        for (int j = 0; j < sys_cols; j++) begin
            col_full[j]      = (cnt[j] == TARGET);
            col_full_next[j] = col_full[j] || ((cnt[j] == TARGET - CNT_W'(1)) && read_out[j]);
            col_ovf[j]       = col_full[j] && read_out[j];
        end
    end

    assign all_done_next = &col_full_next;
    assign overflow      = enable && (|col_ovf);

    // Full columns hold their count: surplus strobes only raise overflow.
    always_ff @(posedge clk) begin
        for (int j = 0; j < sys_cols; j++) begin
            if (!rst || clear)
                cnt[j] <= '0;
            else if (enable && read_out[j] && !col_full[j])
                cnt[j] <= cnt[j] + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Job sequencer: streams weights then activations from their buffers into the array,
// issues the opcode, pulses start and waits for every column to drain its results.
module matmul_sequencer
    import Config::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  job_valid,
    output logic                                  job_ready,
    input  logic [INSTR_SIZE-1:0]                 job_instr,
    output logic                                  w_rd_en,
    output logic [W_ADDR_W-1:0]                   w_rd_addr,
    input  logic [sys_cols-1:0][W_BITWIDTH-1:0]   w_rd_data,
    output logic                                  a_rd_en,
    output logic [A_ADDR_W-1:0]                   a_rd_addr,
    input  logic [A_cols-1:0][W_BITWIDTH-1:0]     a_rd_data,
    output logic [sys_cols-1:0]                   w_valid,
    output logic [sys_cols-1:0][W_BITWIDTH-1:0]   wdata,
    output logic [sys_cols-1:0]                   if_valid,
    output logic [sys_cols-1:0][W_BITWIDTH-1:0]   if_data,
    output logic                                  instr_valid,
    output logic [INSTR_SIZE-1:0]                 instr,
    output logic                                  start,
    input  logic [sys_cols-1:0]                   read_out,
    output logic                                  busy,
    output logic                                  job_done,
    output logic                                  err
);

    localparam logic [A_ADDR_W-1:0] A_LAST = A_ADDR_W'(A_rows - 1);
    localparam logic [WD_W-1:0]     WD_MAX = WD_W'(DRAIN_TIMEOUT - 1);

    seq_state_t            state;
    logic [INSTR_SIZE-1:0] instr_q;
    logic                  err_bit;
    logic [WD_W-1:0]       wd_cnt;
    logic                  all_done_next;
    logic                  overflow;
    logic                  err_next;
    logic                  wd_hit;

    col_drain_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .clear        (state == START),
        .enable       (state == DRAIN),
        .read_out     (read_out),
        .all_done_next(all_done_next),
        .overflow     (overflow)
    );

    assign err_next = err_bit || overflow;
    assign wd_hit   = (read_out == '0) && (wd_cnt == WD_MAX);

    // Buffer data is only forwarded on valid cycles so stale reads never leak out.
    for (genvar j = 0; j < sys_cols; j++) begin : g_col
        assign wdata[j] = w_valid[j] ? w_rd_data[j] : '0;
        if (j < A_cols) begin : g_act
            assign if_data[j] = if_valid[j] ? a_rd_data[j] : '0;
        end else begin : g_pad
            assign if_data[j] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
            w_rd_en     <= 1'b0;
            w_rd_addr   <= '0;
            a_rd_en     <= 1'b0;
            a_rd_addr   <= '0;
            w_valid     <= '0;
            if_valid    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            start       <= 1'b0;
            job_done    <= 1'b0;
            err         <= 1'b0;
            instr_q     <= '0;
            err_bit     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            // Valids trail the read enables by the buffers' one-cycle latency.
            w_valid     <= {sys_cols{w_rd_en}};
            if_valid    <= {sys_cols{a_rd_en}};
            instr_valid <= 1'b0;
            instr       <= '0;
            start       <= 1'b0;
            job_done    <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        instr_q   <= job_instr;
                        err_bit   <= 1'b0;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        w_rd_en   <= 1'b1;
                        w_rd_addr <= W_ADDR_W'(sys_rows - 1);
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_rd_en) begin
                        if (w_rd_addr == '0)
                            w_rd_en <= 1'b0;
                        else
                            w_rd_addr <= w_rd_addr - W_ADDR_W'(1);
                    end else begin
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= '0;
                        state     <= GAP_W;
                    end
                end
                GAP_W, LOAD_A: begin
                    if (a_rd_en) begin
                        if (a_rd_addr == A_LAST) begin
                            a_rd_en   <= 1'b0;
                            a_rd_addr <= '0;
                        end else begin
                            a_rd_addr <= a_rd_addr + A_ADDR_W'(1);
                        end
                    end
                    if (state == GAP_W)
                        state <= LOAD_A;
                    else if (!a_rd_en)
                        state <= GAP_A;
                end
                GAP_A: begin
                    instr_valid <= 1'b1;
                    instr       <= instr_q;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    start <= 1'b1;
                    state <= START;
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    err_bit <= err_next;
                    if (read_out != '0)
                        wd_cnt <= '0;
                    else
                        wd_cnt <= wd_cnt + WD_W'(1);
                    if (all_done_next || wd_hit) begin
                        err_bit  <= err_next || wd_hit;
                        err      <= err_next || wd_hit;
                        job_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer: a timeline model queues expected events per
// accepted job and a negedge monitor matches every DUT output event against it.
module tb_matmul_sequencer;
    import Config::*;

    typedef struct {
        int          ch;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    logic                                clk = 1'b0;
    logic                                rst = 1'b0;
    logic                                job_valid = 1'b0;
    logic                                job_ready;
    logic [INSTR_SIZE-1:0]               job_instr = '0;
    logic                                w_rd_en;
    logic [W_ADDR_W-1:0]                 w_rd_addr;
    logic [sys_cols-1:0][W_BITWIDTH-1:0] w_rd_data = '0;
    logic                                a_rd_en;
    logic [A_ADDR_W-1:0]                 a_rd_addr;
    logic [A_cols-1:0][W_BITWIDTH-1:0]   a_rd_data = '0;
    logic [sys_cols-1:0]                 w_valid;
    logic [sys_cols-1:0][W_BITWIDTH-1:0] wdata;
    logic [sys_cols-1:0]                 if_valid;
    logic [sys_cols-1:0][W_BITWIDTH-1:0] if_data;
    logic                                instr_valid;
    logic [INSTR_SIZE-1:0]               instr;
    logic                                start;
    logic [sys_cols-1:0]                 read_out = '0;
    logic                                busy;
    logic                                job_done;
    logic                                err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    int   busy_from = 0;
    int   idle_from = 0;
    ev_t  exp_q [$];
    logic [23:0] wmem [4];
    logic [23:0] amem [4];
    logic        mon_v [7];
    logic [31:0] mon_d [7];
    bit          exp_ready;
    bit          gate_ok;
    int          d;

    matmul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_instr  (job_instr),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .a_rd_en    (a_rd_en),
        .a_rd_addr  (a_rd_addr),
        .a_rd_data  (a_rd_data),
        .w_valid    (w_valid),
        .wdata      (wdata),
        .if_valid   (if_valid),
        .if_data    (if_data),
        .instr_valid(instr_valid),
        .instr      (instr),
        .start      (start),
        .read_out   (read_out),
        .busy       (busy),
        .job_done   (job_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffers with one-cycle read latency; junk is returned when not enabled.
    always @(posedge clk) begin
        w_rd_data <= w_rd_en ? wmem[w_rd_addr] : 24'($urandom);
        a_rd_data <= a_rd_en ? amem[a_rd_addr] : 24'($urandom);
    end

    function automatic string chname(input int ch);
        case (ch)
            0: return "w_rd";
            1: return "w_stream";
            2: return "a_rd";
            3: return "if_stream";
            4: return "instr";
            5: return "start";
            default: return "job_done";
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            mon_v[0] = w_rd_en;      mon_d[0] = 32'(w_rd_addr);
            mon_v[1] = |w_valid;     mon_d[1] = 32'({w_valid, wdata});
            mon_v[2] = a_rd_en;      mon_d[2] = 32'(a_rd_addr);
            mon_v[3] = |if_valid;    mon_d[3] = 32'({if_valid, if_data});
            mon_v[4] = instr_valid;  mon_d[4] = 32'(instr);
            mon_v[5] = start;        mon_d[5] = 32'(start);
            mon_v[6] = job_done;     mon_d[6] = 32'(err);
            for (int ch = 0; ch < 7; ch++) begin
                bit          found;
                logic [31:0] ed;
                found = 1'b0;
                ed    = '0;
                foreach (exp_q[i])
                    if (exp_q[i].ch == ch && exp_q[i].cyc == cyc) begin
                        found = 1'b1;
                        ed    = exp_q[i].data;
                    end
                if (found || mon_v[ch]) begin
                    n_vec++;
                    if (!(found && mon_v[ch] && mon_d[ch] == ed)) begin
                        n_bad++;
                        $display("FAIL %s cyc=%0d: got valid=%0b data=%h, expected valid=%0b data=%h",
                                 chname(ch), cyc, mon_v[ch], mon_d[ch], found, ed);
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].cyc <= cyc) exp_q.delete(i);

            exp_ready = !(cyc >= busy_from && cyc < idle_from);
            gate_ok   = (w_rd_en || w_rd_addr == '0) && (a_rd_en || a_rd_addr == '0) &&
                        (|w_valid || wdata == '0) && (|if_valid || if_data == '0) &&
                        (instr_valid || instr == '0) && (job_done || !err);
            n_vec++;
            if ({job_ready, busy, gate_ok} != {exp_ready, !exp_ready, 1'b1}) begin
                n_bad++;
                $display("FAIL ctl cyc=%0d: got ready=%0b busy=%0b idle_outputs_zero=%0b, expected ready=%0b busy=%0b idle_outputs_zero=1",
                         cyc, job_ready, busy, gate_ok, exp_ready, !exp_ready);
            end
        end
    end

    task automatic push(input int ch, input int cy, input logic [31:0] dat);
        ev_t e;
        e.ch = ch; e.cyc = cy; e.data = dat;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode: 0 nominal, 1 surplus strobe on column 1, 2 no strobes, 3 job_valid pulse in drain
    task automatic run_job(input int mode, input bit hold, input bit do_rst, input int exp_acc,
                           input logic [INSTR_SIZE-1:0] ins, output int done_cyc);
        int          c;
        int          o;
        int          last;
        int          done;
        bit          acc;
        logic [2:0]  plan [64];
        logic        exp_err;
        for (int r = 0; r < 4; r++) begin
            wmem[r] = 24'($urandom);
            amem[r] = 24'($urandom);
        end
        job_instr = ins;
        job_valid = 1'b1;
        acc = 1'b0;
        c = 0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            if (job_ready) begin
                acc = 1'b1;
                c = cyc;
            end
        end
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL accept: got no job_ready in 40 cycles, expected an accept");
            job_valid = 1'b0;
            done_cyc = cyc;
            return;
        end
        if (exp_acc >= 0) begin
            n_vec++;
            if (c != exp_acc) begin
                n_bad++;
                $display("FAIL accept_cycle: got %0d, expected %0d", c, exp_acc);
            end
        end

        busy_from = c + 1;
        idle_from = 32'h3fff_ffff;
        for (int k = 0; k < 3; k++) begin
            push(0, c + 1 + k, 32'(2 - k));
            push(1, c + 2 + k, 32'({3'b111, wmem[2 - k]}));
        end
        for (int k = 0; k < 4; k++) begin
            push(2, c + 5 + k, 32'(k));
            push(3, c + 6 + k, 32'({3'b111, amem[k]}));
        end
        push(4, c + 11, 32'(ins));
        push(5, c + 12, 32'd1);

        @(posedge clk);
        #1;
        if (!hold) job_valid = 1'b0;

        if (do_rst) begin
            goto(c + 7);
            rst = 1'b0;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].cyc >= c + 8) exp_q.delete(i);
            idle_from = c + 8;
            @(posedge clk);
            #1;
            rst = 1'b1;
            done_cyc = c + 7;
            return;
        end

        for (int k = 0; k < 64; k++) plan[k] = '0;
        last = 0;
        if (mode == 1) begin
            for (int k = 0; k < 5; k++) plan[k][1] = 1'b1;
            for (int j = 0; j < 3; j += 2) begin
                o = $urandom_range(5, 7);
                for (int k = 0; k < 4; k++) begin
                    plan[o][j] = 1'b1;
                    if (o > last) last = o;
                    o += $urandom_range(1, 4);
                end
            end
        end else if (mode != 2) begin
            for (int j = 0; j < 3; j++) begin
                o = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) begin
                    plan[o][j] = 1'b1;
                    if (o > last) last = o;
                    o += $urandom_range(1, 4);
                end
            end
        end
        if (mode == 2) begin
            done = c + 13 + DRAIN_TIMEOUT;
            exp_err = 1'b1;
        end else begin
            done = c + 13 + last + 1;
            exp_err = (mode == 1);
        end
        push(6, done, 32'(exp_err));
        idle_from = done + 1;

        if (mode != 2) begin
            for (int k = 0; k <= last; k++) begin
                goto(c + 13 + k);
                read_out = plan[k];
                if (mode == 3) job_valid = (k == 2);
            end
            goto(c + 13 + last + 1);
            read_out = '0;
            if (mode == 3) job_valid = 1'b0;
        end
        goto(done + 1);
        done_cyc = done;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(2);

        run_job(0, 1'b0, 1'b0, -1, 2'b11, d);
        idle(6);
        repeat (3) begin
            run_job(0, 1'b0, 1'b0, -1, 2'($urandom_range(0, 3)), d);
            idle(4);
        end

        run_job(0, 1'b1, 1'b0, -1, 2'b01, d);
        run_job(0, 1'b0, 1'b0, d + 1, 2'b10, d);
        idle(5);

        run_job(1, 1'b0, 1'b0, -1, 2'b11, d);
        run_job(0, 1'b0, 1'b0, -1, 2'b00, d);
        idle(4);

        run_job(2, 1'b0, 1'b0, -1, 2'b10, d);
        idle(4);

        run_job(0, 1'b0, 1'b1, -1, 2'b01, d);
        idle(4);
        run_job(0, 1'b0, 1'b0, -1, 2'b11, d);
        idle(4);

        run_job(3, 1'b0, 1'b0, -1, 2'b10, d);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
